id_ex_pipe_reg: RTL and testbench

ID/EX pipeline stage register for the 5-stage MIPS pipeline. It sits directly downstream of the main opcode controller. It captures the controller's 10 control signals together with the decoded operands, and presents them to EX one cycle later. It also contains load-use hazard detection: it stalls IF/ID and inserts a bubble, squashes on branch/jump flush, and keeps saturating stall/flush event counters.

---
 rtl/id_ex_pipe_reg.sv | 127 ++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing
// and saturating stall/flush event counters.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [9:0]        id_ctrl,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [9:0]        ex_ctrl,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Bit positions inside the controller bundle
  localparam int JUMP     = 8;
  localparam int MEMREAD  = 6;
  localparam int MEMWRITE = 2;
  localparam int ALUSRC   = 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              exValid_q, exValid_d;
  logic [9:0]        exCtrl_q, exCtrl_d;
  logic [DATA_W-1:0] exRd1_q, exRd1_d, exRd2_q, exRd2_d;
  logic [DATA_W-1:0] exImm_q, exImm_d, exPc4_q, exPc4_d;
  logic [RA_W-1:0]   exRs_q, exRs_d, exRt_q, exRt_d, exRd_q, exRd_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d, flushCnt_q, flushCnt_d;

  logic rsUsed, rtUsed, hazard;

  // A load in EX whose destination feeds a source the ID instruction reads
  assign rsUsed = ~id_ctrl[JUMP];
  assign rtUsed = ~id_ctrl[ALUSRC] | id_ctrl[MEMWRITE];
  assign hazard = id_valid & exValid_q & exCtrl_q[MEMREAD] & (exRt_q != '0) &
                  ((rsUsed & (exRt_q == id_rs)) | (rtUsed & (exRt_q == id_rt)));
  assign stall  = hazard & ~flush;

  always_comb begin
    exValid_d  = 1'b0;
    exCtrl_d   = '0;
    exRd1_d    = '0;
    exRd2_d    = '0;
    exImm_d    = '0;
    exPc4_d    = '0;
    exRs_d     = '0;
    exRt_d     = '0;
    exRd_d     = '0;
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    // Flush and stall both leave an all-zero bubble; otherwise load ID
    if (!flush && !hazard) begin
      exValid_d = id_valid;
      exCtrl_d  = id_valid ? id_ctrl : 10'b0;
      exRd1_d   = id_rd1;
      exRd2_d   = id_rd2;
      exImm_d   = id_imm;
      exPc4_d   = id_pc4;
      exRs_d    = id_rs;
      exRt_d    = id_rt;
      exRd_d    = id_rd;
    end
    if (stall && stallCnt_q != CNT_MAX) stallCnt_d = stallCnt_q + CNT_ONE;
    if (flush && flushCnt_q != CNT_MAX) flushCnt_d = flushCnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exValid_q  <= 1'b0;
      exCtrl_q   <= '0;
      exRd1_q    <= '0;
      exRd2_q    <= '0;
      exImm_q    <= '0;
      exPc4_q    <= '0;
      exRs_q     <= '0;
      exRt_q     <= '0;
      exRd_q     <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      exValid_q  <= exValid_d;
      exCtrl_q   <= exCtrl_d;
      exRd1_q    <= exRd1_d;
      exRd2_q    <= exRd2_d;
      exImm_q    <= exImm_d;
      exPc4_q    <= exPc4_d;
      exRs_q     <= exRs_d;
      exRt_q     <= exRt_d;
      exRd_q     <= exRd_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign ex_valid  = exValid_q;
  assign ex_ctrl   = exCtrl_q;
  assign ex_rd1    = exRd1_q;
  assign ex_rd2    = exRd2_q;
  assign ex_imm    = exImm_q;
  assign ex_pc4    = exPc4_q;
  assign ex_rs     = exRs_q;
  assign ex_rt     = exRt_q;
  assign ex_rd     = exRd_q;
  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized bench for id_ex_pipe_reg against a behavioural pipeline model;
// a second instance with 4-bit counters exercises saturation.
module tb_id_ex_pipe_reg;

  localparam logic [9:0] LW   = 10'b0001100011;
  localparam logic [9:0] ADD  = 10'b1000010001;
  localparam logic [9:0] ADDI = 10'b0000000011;
  localparam logic [9:0] SW   = 10'b0000000110;
  localparam logic [9:0] JMP  = 10'b0100000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, idValid, flush;
  logic [9:0]  idCtrl;
  logic [31:0] idRd1, idRd2, idImm, idPc4;
  logic [4:0]  idRs, idRt, idRd;

  logic        stall, exValid;
  logic [9:0]  exCtrl;
  logic [31:0] exRd1, exRd2, exImm, exPc4;
  logic [4:0]  exRs, exRt, exRd;
  logic [15:0] stallCnt, flushCnt;

  logic        sStall, sValid;
  logic [9:0]  sCtrl;
  logic [31:0] sRd1, sRd2, sImm, sPc4;
  logic [4:0]  sRs, sRt, sRd;
  logic [3:0]  sStallCnt, sFlushCnt;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_ctrl(idCtrl),
    .id_rd1(idRd1), .id_rd2(idRd2), .id_imm(idImm), .id_pc4(idPc4),
    .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .flush(flush),
    .stall(stall), .ex_valid(exValid), .ex_ctrl(exCtrl),
    .ex_rd1(exRd1), .ex_rd2(exRd2), .ex_imm(exImm), .ex_pc4(exPc4),
    .ex_rs(exRs), .ex_rt(exRt), .ex_rd(exRd),
    .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  id_ex_pipe_reg #(.CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_ctrl(idCtrl),
    .id_rd1(idRd1), .id_rd2(idRd2), .id_imm(idImm), .id_pc4(idPc4),
    .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .flush(flush),
    .stall(sStall), .ex_valid(sValid), .ex_ctrl(sCtrl),
    .ex_rd1(sRd1), .ex_rd2(sRd2), .ex_imm(sImm), .ex_pc4(sPc4),
    .ex_rs(sRs), .ex_rt(sRt), .ex_rd(sRd),
    .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
  );

  // Model state: what EX should hold, plus event counts at both widths
  logic        mValid;
  logic [9:0]  mCtrl;
  logic [31:0] mRd1, mRd2, mImm, mPc4;
  logic [4:0]  mRs, mRt, mRd;
  int          mStalls, mFlushes;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic modelStall();
    logic readsRs, readsRt, loadInEx;
    readsRs  = (idCtrl[8] == 1'b0);
    readsRt  = (idCtrl[1] == 1'b0) || (idCtrl[2] == 1'b1);
    loadInEx = idValid && mValid && mCtrl[6] && (mRt != 5'd0);
    return loadInEx && ((readsRs && mRt == idRs) || (readsRt && mRt == idRt));
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic modelEdge();
    logic hz;
    hz = modelStall();
    if (rst) begin
      {mValid, mCtrl, mRd1, mRd2, mImm, mPc4, mRs, mRt, mRd} = '0;
      mStalls = 0;
      mFlushes = 0;
    end else begin
      if (hz && !flush) mStalls++;
      if (flush) mFlushes++;
      if (flush || hz) begin
        {mValid, mCtrl, mRd1, mRd2, mImm, mPc4, mRs, mRt, mRd} = '0;
      end else begin
        mValid = idValid;
        mCtrl  = idValid ? idCtrl : 10'd0;
        mRd1 = idRd1; mRd2 = idRd2; mImm = idImm; mPc4 = idPc4;
        mRs = idRs; mRt = idRt; mRd = idRd;
      end
    end
  endtask

  // One clock: check combinational stall, clock the model, check EX state
  task automatic applyStimulus();
    logic expStall;
    #1;
    expStall = modelStall() && !flush;
    checkOutput("stall", 64'(stall), 64'(expStall));
    checkOutput("stallSat", 64'(sStall), 64'(expStall));
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("exValid", 64'(exValid), 64'(mValid));
    checkOutput("exCtrl", 64'(exCtrl), 64'(mCtrl));
    checkOutput("exRd1", 64'(exRd1), 64'(mRd1));
    checkOutput("exRd2", 64'(exRd2), 64'(mRd2));
    checkOutput("exImm", 64'(exImm), 64'(mImm));
    checkOutput("exPc4", 64'(exPc4), 64'(mPc4));
    checkOutput("exRs", 64'(exRs), 64'(mRs));
    checkOutput("exRt", 64'(exRt), 64'(mRt));
    checkOutput("exRd", 64'(exRd), 64'(mRd));
    checkOutput("stallCnt", 64'(stallCnt), 64'(sat(mStalls, 65535)));
    checkOutput("flushCnt", 64'(flushCnt), 64'(sat(mFlushes, 65535)));
    checkOutput("satCtrl", 64'(sCtrl), 64'(mCtrl));
    checkOutput("satStallCnt", 64'(sStallCnt), 64'(sat(mStalls, 15)));
    checkOutput("satFlushCnt", 64'(sFlushCnt), 64'(sat(mFlushes, 15)));
  endtask

  function automatic logic [4:0] pickReg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [9:0] pickCtrl();
    case ($urandom_range(0, 5))
      0:       return LW;
      1:       return ADD;
      2:       return ADDI;
      3:       return SW;
      4:       return JMP;
      default: return 10'($urandom);
    endcase
  endfunction

  task automatic randomInputs();
    idValid = ($urandom_range(0, 7) != 0);
    idCtrl  = pickCtrl();
    idRd1 = $urandom; idRd2 = $urandom; idImm = $urandom; idPc4 = $urandom;
    idRs = pickReg(); idRt = pickReg(); idRd = 5'($urandom);
  endtask

  task automatic setInstr(input logic [9:0] c, input logic [4:0] rs,
                          input logic [4:0] rt);
    idValid = 1'b1;
    idCtrl  = c;
    idRs    = rs;
    idRt    = rt;
  endtask

  initial begin
    {mValid, mCtrl, mRd1, mRd2, mImm, mPc4, mRs, mRt, mRd} = '0;
    mStalls = 0;
    mFlushes = 0;

    rst = 1'b1;
    flush = 1'($urandom);
    randomInputs();
    @(posedge clk);
    modelEdge();
    randomInputs();
    flush = 1'($urandom);
    applyStimulus();
    checkOutput("rstValid", 64'(exValid), 64'd0);
    checkOutput("rstCtrl", 64'(exCtrl), 64'd0);
    checkOutput("rstStallCnt", 64'(stallCnt), 64'd0);
    checkOutput("rstFlushCnt", 64'(flushCnt), 64'd0);
    checkOutput("rstStall", 64'(stall), 64'd0);

    rst = 1'b0;
    flush = 1'b0;
    setInstr(ADD, 5'd1, 5'd2);
    idRd1 = 32'd5; idRd2 = 32'd7; idRd = 5'd3;
    applyStimulus();
    checkOutput("passCtrl", 64'(exCtrl), 64'(ADD));
    checkOutput("passRd1", 64'(exRd1), 64'd5);
    checkOutput("passRd2", 64'(exRd2), 64'd7);
    checkOutput("passRd", 64'(exRd), 64'd3);
    checkOutput("passValid", 64'(exValid), 64'd1);

    setInstr(LW, 5'd1, 5'd8);
    applyStimulus();
    setInstr(ADD, 5'd8, 5'd9);
    #1 checkOutput("luStall", 64'(stall), 64'd1);
    applyStimulus();
    checkOutput("luBubbleValid", 64'(exValid), 64'd0);
    checkOutput("luBubbleCtrl", 64'(exCtrl), 64'd0);
    #1 checkOutput("luStallOnce", 64'(stall), 64'd0);
    applyStimulus();
    checkOutput("luAddCtrl", 64'(exCtrl), 64'(ADD));
    checkOutput("luStallCnt", 64'(stallCnt), 64'd1);

    setInstr(LW, 5'd1, 5'd8);
    applyStimulus();
    setInstr(ADDI, 5'd9, 5'd8);
    #1 checkOutput("addiNoStall", 64'(stall), 64'd0);
    applyStimulus();
    setInstr(LW, 5'd1, 5'd0);
    applyStimulus();
    setInstr(ADD, 5'd0, 5'd0);
    #1 checkOutput("zeroRegNoStall", 64'(stall), 64'd0);
    applyStimulus();

    setInstr(LW, 5'd1, 5'd8);
    applyStimulus();
    setInstr(ADD, 5'd8, 5'd9);
    flush = 1'b1;
    #1 checkOutput("flushNoStall", 64'(stall), 64'd0);
    applyStimulus();
    flush = 1'b0;
    checkOutput("flushValid", 64'(exValid), 64'd0);
    checkOutput("flushCnt1", 64'(flushCnt), 64'd1);
    checkOutput("flushStallCnt", 64'(stallCnt), 64'd1);

    for (int i = 0; i < 20; i++) begin
      setInstr(LW, 5'd1, 5'd8);
      applyStimulus();
      setInstr(ADD, 5'd8, 5'd9);
      applyStimulus();
    end
    checkOutput("satStop", 64'(sStallCnt), 64'd15);
    checkOutput("wideCount", 64'(stallCnt), 64'd21);

    for (int i = 0; i < 1500; i++) begin
      randomInputs();
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 7) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
